// File: rtl/cnt_pkg.sv
// Shared constants for the up/down counter: direction encodings and default width.
package cnt_pkg;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int   CNT_W    = 3;
endpackage

// File: rtl/mycount_next.sv
// Next-value logic for the counter: q+1 when counting up, q-1 when counting down.
// Combinational, zero latency; no backpressure.
module mycount_next
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic [WIDTH-1:0] q,
    input  logic             direction,
    output logic [WIDTH-1:0] q_next
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Ternary rather than if/else so an unknown direction propagates as X
    // instead of silently selecting the down path.
    assign q_next = (direction == DIR_UP) ? (q + ONE) : (q - ONE);

endmodule

// File: rtl/mycount.sv
// Free-running modulo-2**WIDTH up/down counter; q updates one clock after direction is sampled.
// No enable or load, never stalls; an asynchronous active-low reset clears q.
module mycount
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             direction,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    mycount_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .q        (q),
        .direction(direction),
        .q_next   (q_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_mycount.sv
// Directed bench for mycount: reset, count up/down, both wraps, mid-count reset, direction toggling.
module tb_mycount;
    import cnt_pkg::*;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       direction = DIR_UP;
    logic [2:0] q;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    mycount #(
        .WIDTH(CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .direction(direction),
        .q        (q)
    );

    // Reset asserts at t=1 with no clock edge; q must clear at once and hold through t=10.
    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if (q !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: q=%0d expected 0 at t=%0t", q, $time);
        end
        @(posedge clock);
        #1;
        checks++;
        if (q !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold: q=%0d expected 0 at t=%0t", q, $time);
        end
        #10 reset = 1'b1;
        direction = DIR_UP;
    endtask

    task automatic test_count_up();
        for (int i = 1; i <= 7; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (q !== 3'(i)) begin
                errors++;
                $display("FAIL count_up: q=%0d expected %0d at t=%0t", q, i, $time);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [2:0] exp_vals [2] = '{3'd0, 3'd1};
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (q !== exp_vals[i]) begin
                errors++;
                $display("FAIL up_wrap: q=%0d expected %0d at t=%0t", q, exp_vals[i], $time);
            end
        end
    endtask

    // From q=1 counting down: 0, wrap to 7, 6, then 5 to set up the mid-count reset.
    task automatic test_down_wrap();
        logic [2:0] exp_vals [4] = '{3'd0, 3'd7, 3'd6, 3'd5};
        direction = DIR_DOWN;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (q !== exp_vals[i]) begin
                errors++;
                $display("FAIL down_wrap: q=%0d expected %0d at t=%0t", q, exp_vals[i], $time);
            end
        end
    endtask

    task automatic test_reset_mid();
        #4 reset = 1'b0;
        #1;
        checks++;
        if (q !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_async: q=%0d expected 0 at t=%0t", q, $time);
        end
        direction = DIR_UP;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (q !== 3'd0) begin
                errors++;
                $display("FAIL reset_mid_hold: q=%0d expected 0 at t=%0t", q, $time);
            end
        end
        #4 reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (q !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid_release: q=%0d expected 1 at t=%0t", q, $time);
        end
    endtask

    task automatic test_dir_toggle();
        logic       dirs     [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] exp_vals [6] = '{3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3};
        for (int i = 0; i < 6; i++) begin
            direction = dirs[i];
            @(posedge clock);
            #1;
            checks++;
            if (q !== exp_vals[i]) begin
                errors++;
                $display("FAIL dir_toggle: step %0d q=%0d expected %0d at t=%0t",
                         i, q, exp_vals[i], $time);
            end
        end
    endtask

    // 1000 ns of free-running up count after a fresh release: q tracks edges mod 8.
    task automatic test_free_run();
        logic [2:0] exp_q;
        reset = 1'b0;
        #1;
        checks++;
        if (q !== 3'd0) begin
            errors++;
            $display("FAIL free_run_reset: q=%0d expected 0 at t=%0t", q, $time);
        end
        #4 reset = 1'b1;
        direction = DIR_UP;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clock);
            #1;
            exp_q = 3'(n % 8);
            checks++;
            if (q !== exp_q) begin
                errors++;
                $display("FAIL free_run: edge %0d q=%0d expected %0d at t=%0t",
                         n, q, exp_q, $time);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_up_wrap();
        test_down_wrap();
        test_reset_mid();
        test_dir_toggle();
        test_free_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
